trig_capture: RTL and testbench

//   Triggered sample capture buffer downstream of the sine generator ROM output.

---
 rtl/trig_capture_if.sv | 32 +++
 rtl/trig_capture.sv | 143 ++++++++++++++
 tb/tb_trig_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/trig_capture_if.sv
// ---------------------------------------------------------------------------
// trig_capture_if : sample stream, trigger control and readback signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface trig_capture_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] level;
  logic                  arm;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  done;
  logic                  busy;
  logic [1:0]            state;

  modport master (
    output en, din, level, arm, rd_en,
    input  rd_data, rd_valid, done, busy, state
  );

  modport slave (
    input  en, din, level, arm, rd_en,
    output rd_data, rd_valid, done, busy, state
  );
endinterface

`default_nettype wire

// File: rtl/trig_capture.sv
// ---------------------------------------------------------------------------
// trig_capture : rising-level triggered capture of 2**DEPTH_LOG2 samples
//                with continuous wrap-around replay
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trig_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst,
  trig_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAP  = 2'd2,
    S_FULL = 2'd3
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] c_PTR_LAST = '1;
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_ram [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0]   r_prev;
  logic                    r_prev_valid;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;
  logic                    w_trig;
  logic                    w_wr;
  logic [DEPTH_LOG2-1:0]   w_wr_addr;
  logic                    w_rd;
  logic                    w_rearm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // level=0 can never trigger because prev<0 is impossible unsigned
  always_comb begin
    w_state_nxt = r_state;
    w_trig      = 1'b0;
    w_wr        = 1'b0;
    w_wr_addr   = r_wr_ptr;
    w_rd        = 1'b0;
    w_rearm     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.arm) begin
          w_state_nxt = S_WAIT;
          w_rearm     = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.en && r_prev_valid && (r_prev < bus.level) && (bus.din >= bus.level)) begin
          w_trig      = 1'b1;
          w_wr        = 1'b1;
          w_wr_addr   = '0;
          w_state_nxt = S_CAP;
        end
      end
      S_CAP: begin
        if (bus.en) begin
          w_wr = 1'b1;
          if (r_wr_ptr == c_PTR_LAST) begin
            w_state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (bus.arm) begin
          w_state_nxt = S_WAIT;
          w_rearm     = 1'b1;
        end else if (bus.rd_en) begin
          w_rd = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      if (w_rearm) begin
        r_prev_valid <= 1'b0;
      end else if ((r_state == S_WAIT) && bus.en) begin
        r_prev       <= bus.din;
        r_prev_valid <= 1'b1;
      end

      if (w_trig) begin
        r_wr_ptr <= c_PTR_ONE;
      end else if ((r_state == S_CAP) && bus.en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if ((r_state == S_FULL) && bus.arm) begin
        r_rd_ptr <= '0;
      end else if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= r_ram[r_rd_ptr];
      end
    end
  end

  // Storage array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_ram[w_wr_addr] <= bus.din;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.done     = (r_state == S_FULL);
  assign bus.busy     = (r_state == S_WAIT) || (r_state == S_CAP);
  assign bus.state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_trig_capture.sv
// ---------------------------------------------------------------------------
// tb_trig_capture : directed bench with a queue-based capture model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_trig_capture;

  localparam int DW    = 8;
  localparam int DL    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trig_capture_if #(.DATA_WIDTH(DW)) bus_if ();

  trig_capture #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: a list of captured samples plus a read index into it
  int m_st    = 0;
  int m_prev  = 0;
  bit m_pv    = 1'b0;
  int m_rd    = 0;
  bit m_rv    = 1'b0;
  int m_rdata = 0;
  int cap[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_prev = 0; m_pv = 1'b0; m_rd = 0; m_rv = 1'b0; m_rdata = 0;
      cap.delete();
    end else begin
      m_rv = 1'b0;
      case (m_st)
        0: if (bus_if.arm) begin m_st = 1; m_pv = 1'b0; end
        1: if (bus_if.en) begin
             if (m_pv && (m_prev < int'(bus_if.level)) && (int'(bus_if.din) >= int'(bus_if.level))) begin
               cap.delete();
               cap.push_back(int'(bus_if.din));
               m_st = 2;
             end
             m_prev = int'(bus_if.din);
             m_pv   = 1'b1;
           end
        2: if (bus_if.en) begin
             cap.push_back(int'(bus_if.din));
             if (cap.size() == DEPTH) m_st = 3;
           end
        default: begin
          if (bus_if.arm) begin
            m_st = 1; m_pv = 1'b0; m_rd = 0;
          end else if (bus_if.rd_en) begin
            m_rdata = cap[m_rd];
            m_rv    = 1'b1;
            m_rd    = (m_rd + 1) % DEPTH;
          end
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_state",    32'(bus_if.state),    32'(m_st));
      chk("m_done",     32'(bus_if.done),     32'(m_st == 3));
      chk("m_busy",     32'(bus_if.busy),     32'((m_st == 1) || (m_st == 2)));
      chk("m_rd_valid", 32'(bus_if.rd_valid), 32'(m_rv));
      if (m_rv) chk("m_rd_data", 32'(bus_if.rd_data), 32'(m_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sawtooth din=start..start+n-1; optional idle cycle after each sample
  task automatic feed(input int start, input int n, input bit gaps, input int arm_at);
    for (int i = start; i < start + n; i++) begin
      bus_if.en  = 1'b1;
      bus_if.din = 8'(i);
      bus_if.arm = (i == arm_at);
      tick();
      if (gaps) begin
        bus_if.en  = 1'b0;
        bus_if.din = 8'hA5;
        bus_if.arm = 1'b0;
        tick();
      end
    end
    bus_if.en  = 1'b0;
    bus_if.arm = 1'b0;
  endtask

  task automatic read_n(input int n, input int first);
    bus_if.rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rd_valid", 32'(bus_if.rd_valid), 32'd1);
      chk("rd_data",  32'(bus_if.rd_data),  32'((first + i) % 256));
    end
    bus_if.rd_en = 1'b0;
    tick();
    chk("rd_valid_idle", 32'(bus_if.rd_valid), 32'd0);
  endtask

  initial begin
    bus_if.en = 1'b0; bus_if.din = '0; bus_if.level = '0;
    bus_if.arm = 1'b0; bus_if.rd_en = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_state",    32'(bus_if.state),    32'd0);
    chk("rst_done",     32'(bus_if.done),     32'd0);
    chk("rst_busy",     32'(bus_if.busy),     32'd0);
    chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk("rst_rd_data",  32'(bus_if.rd_data),  32'd0);
    rst = 1'b0;

    bus_if.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rd_valid", 32'(bus_if.rd_valid), 32'd0);
      chk("idle_state",    32'(bus_if.state),    32'd0);
    end
    bus_if.rd_en = 1'b0;

    // Capture 1: continuous en, stray arm in CAP
    bus_if.level = 8'd128;
    bus_if.arm = 1'b1; tick(); bus_if.arm = 1'b0;
    chk("arm_state", 32'(bus_if.state), 32'd1);
    chk("arm_busy",  32'(bus_if.busy),  32'd1);
    feed(0, 383, 1'b0, 200);
    chk("cap1_pre_state", 32'(bus_if.state), 32'd2);
    chk("cap1_pre_done",  32'(bus_if.done),  32'd0);
    feed(383, 1, 1'b0, -1);
    chk("cap1_state", 32'(bus_if.state), 32'd3);
    chk("cap1_done",  32'(bus_if.done),  32'd1);
    read_n(258, 128);

    // Rearm with simultaneous read
    bus_if.arm = 1'b1; bus_if.rd_en = 1'b1; tick();
    bus_if.arm = 1'b0; bus_if.rd_en = 1'b0;
    chk("rearm_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk("rearm_done",     32'(bus_if.done),     32'd0);
    chk("rearm_state",    32'(bus_if.state),    32'd1);

    // Capture 2: en toggling
    feed(0, 383, 1'b1, -1);
    chk("cap2_pre_state", 32'(bus_if.state), 32'd2);
    feed(383, 1, 1'b1, -1);
    chk("cap2_state", 32'(bus_if.state), 32'd3);
    read_n(256, 128);

    // Reset in the middle of a capture (wr_ptr=50)
    bus_if.arm = 1'b1; tick(); bus_if.arm = 1'b0;
    feed(0, 178, 1'b0, -1);
    chk("mid_cap_state", 32'(bus_if.state), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state",    32'(bus_if.state),    32'd0);
    chk("arst_done",     32'(bus_if.done),     32'd0);
    chk("arst_busy",     32'(bus_if.busy),     32'd0);
    chk("arst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk("arst_rd_data",  32'(bus_if.rd_data),  32'd0);
    tick();
    rst = 1'b0;

    // Levels that must never trigger with din held at 200
    bus_if.level = 8'd0;
    bus_if.arm = 1'b1; tick(); bus_if.arm = 1'b0;
    bus_if.en = 1'b1; bus_if.din = 8'd200;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lvl0_state", 32'(bus_if.state), 32'd1);
    end
    bus_if.level = 8'd128;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lvl128_state", 32'(bus_if.state), 32'd1);
    end
    bus_if.en = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
